// File: rtl/bin_frame_writer_if.sv
// Signal bundle between the binarized pixel stream / status consumer and the frame writer.
interface bin_frame_writer_if #(
    parameter int ADDR_W = 17
);
    logic              frame_start;
    logic              pix_valid;
    logic              pix_in;
    logic              err_clr;
    logic              wr_ce;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_din;
    logic              busy;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              short_frame;
    logic              overrun;

    modport master (
        output frame_start, pix_valid, pix_in, err_clr,
        input  wr_ce, wr_addr, wr_din, busy, frame_done, frame_cnt, short_frame, overrun
    );

    modport slave (
        input  frame_start, pix_valid, pix_in, err_clr,
        output wr_ce, wr_addr, wr_din, busy, frame_done, frame_cnt, short_frame, overrun
    );
endinterface

// File: rtl/bin_frame_writer.sv
// Writes one 1-bit raster frame per frame_start into SDPB port A at linear addresses.
module bin_frame_writer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic             clk_out,
    input  logic             rst_n,
    bin_frame_writer_if.slave bus
);
    localparam longint NPIX = longint'(H_ACTIVE) * longint'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    if (NPIX > (longint'(1) << ADDR_W)) begin : g_addr_check
        $error("bin_frame_writer: H_ACTIVE*V_ACTIVE does not fit in ADDR_W");
    end

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_ce_q, wr_ce_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_din_q, wr_din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              short_q, short_d;
    logic              ovr_q, ovr_d;

    logic [ADDR_W-1:0] wa;
    logic              accept;
    logic              last_px;

    // frame_start forces the write address of a coincident pixel to 0
    assign wa      = bus.frame_start ? '0 : addr_q;
    assign accept  = bus.pix_valid & (bus.frame_start | (state_q == WRITE));
    assign last_px = accept & (wa == LAST);

    always_ff @(posedge clk_out) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.frame_start) state_d = last_px ? DONE : WRITE;
                else                 state_d = IDLE;
            end
            WRITE:   if (last_px) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (accept)               addr_d = last_px ? '0 : wa + ADDR_W'(1);
        else if (bus.frame_start) addr_d = '0;
        wr_ce_d   = accept;
        wr_addr_d = accept ? wa : wr_addr_q;
        wr_din_d  = accept ? bus.pix_in : wr_din_q;
        busy_d    = (state_d == WRITE);
        done_d    = (state_d == DONE);
        cnt_d     = cnt_q + 8'(state_d == DONE);
        // set beats clear when both land in the same cycle
        short_d   = (bus.frame_start & (state_q == WRITE)) | (short_q & ~bus.err_clr);
        ovr_d     = (bus.pix_valid & ~accept) | (ovr_q & ~bus.err_clr);
    end

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wr_ce_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wr_ce_q   <= wr_ce_d;
            wr_addr_q <= wr_addr_d;
            wr_din_q  <= wr_din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.wr_ce       = wr_ce_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_din      = wr_din_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_cnt   = cnt_q;
    assign bus.short_frame = short_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_bin_frame_writer.sv
// Scoreboard bench for bin_frame_writer on a 4x2 frame: directed scenarios then random traffic.
module tb_bin_frame_writer;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;
    localparam int N  = H * V;

    typedef struct {
        logic [AW-1:0] a;
        logic          d;
    } wr_t;

    logic clk_out = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_out = ~clk_out;

    bin_frame_writer_if #(.ADDR_W(AW)) bus ();

    bin_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk_out(clk_out),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_tot  = 0;
    int n_pass = 0;

    // reference model: a frame is "open" from frame_start until N pixels have landed
    wr_t           exp_q[$];
    bit            m_in    = 0;
    int            m_idx   = 0;
    int            m_cnt   = 0;
    bit            m_short = 0;
    bit            m_ovr   = 0;
    bit            m_done  = 0;
    logic [AW-1:0] m_la    = '0;
    logic          m_ld    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial forever begin
        bit sset, oset;
        @(posedge clk_out);
        if (!rst_n) begin
            exp_q.delete();
            m_in = 0; m_idx = 0; m_cnt = 0; m_short = 0; m_ovr = 0; m_done = 0;
            m_la = '0; m_ld = 1'b0;
        end else begin
            m_done = 0;
            sset   = bus.frame_start && m_in;
            oset   = 0;
            if (bus.frame_start) begin
                m_in  = 1;
                m_idx = 0;
            end
            if (bus.pix_valid) begin
                if (m_in) begin
                    exp_q.push_back('{AW'(m_idx), bus.pix_in});
                    m_la = AW'(m_idx);
                    m_ld = bus.pix_in;
                    m_idx++;
                    if (m_idx == N) begin
                        m_in   = 0;
                        m_done = 1;
                        m_cnt  = (m_cnt + 1) % 256;
                    end
                end else begin
                    oset = 1;
                end
            end
            m_short = sset | (m_short & !bus.err_clr);
            m_ovr   = oset | (m_ovr & !bus.err_clr);
        end
    end

    initial forever begin
        wr_t e;
        @(negedge clk_out);
        if (bus.wr_ce) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(bus.wr_addr), int'(e.a));
                chk("wr_din", int'(bus.wr_din), int'(e.d));
            end
        end else begin
            chk("missing_write", exp_q.size(), 0);
            exp_q.delete();
            chk("wr_addr_hold", int'(bus.wr_addr), int'(m_la));
            chk("wr_din_hold", int'(bus.wr_din), int'(m_ld));
        end
        chk("busy", int'(bus.busy), int'(m_in));
        chk("frame_done", int'(bus.frame_done), int'(m_done));
        chk("frame_cnt", int'(bus.frame_cnt), m_cnt);
        chk("short_frame", int'(bus.short_frame), int'(m_short));
        chk("overrun", int'(bus.overrun), int'(m_ovr));
    end

    task automatic drive(input logic fs, input logic pv, input logic px, input logic clr);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.pix_in      = px;
        bus.err_clr     = clr;
        @(posedge clk_out);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b10110010;
        bus.frame_start = 0; bus.pix_valid = 0; bus.pix_in = 0; bus.err_clr = 0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // full frame, continuous valid
        for (int i = 0; i < N; i++) drive(i == 0, 1, pat[7-i], 0);
        idle(3);

        // gapped valid
        for (int i = 0; i < 2*N; i++) drive(i == 0, (i % 2) == 0, pat[7-i/2], 0);
        idle(3);

        // short frame: restart after 3 pixels
        for (int i = 0; i < 3; i++) drive(i == 0, 1, pat[7-i], 0);
        for (int i = 0; i < N; i++) drive(i == 0, 1, pat[i], 0);
        idle(2);
        drive(0, 0, 0, 1);
        idle(1);

        // stray pixels in IDLE and in the DONE cycle, then clear, then set-vs-clear
        drive(0, 1, 1, 0);
        idle(1);
        for (int i = 0; i < N; i++) drive(i == 0, 1, pat[7-i], 0);
        drive(0, 1, 0, 0);
        idle(1);
        drive(0, 0, 0, 1);
        drive(0, 1, 1, 1);
        drive(0, 0, 0, 1);
        idle(2);

        // back-to-back frames, enough for frame_cnt to wrap
        for (int f = 0; f < 256; f++)
            for (int i = 0; i < N; i++) drive(i == 0, 1, 1'($urandom), 0);
        idle(3);

        // reset mid-frame
        for (int i = 0; i < 5; i++) drive(i == 0, 1, pat[7-i], 0);
        rst_n = 1'b0;
        drive(0, 1, 1, 0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < N; i++) drive(i == 0, 1, pat[i], 0);
        idle(2);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom % 600) != 0;
            drive(($urandom % 12) == 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0);
        end
        rst_n = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/bin_frame_writer.md
# bin_frame_writer

Writer side of the 1-bit binary frame buffer. Accepts a thresholded camera pixel stream (one bit per pixel, raster order) and drives port A of a Gowin_SDPB instance (`cea`, `ada`, `din`), producing linear write addresses for one full frame per `frame_start`. It sits between the camera binarization stage and the frame-buffer RAMs that the display/filter path reads sequentially on port B.

## Interface

Parameters:
- `H_ACTIVE`, 320, pixels per line.
- `V_ACTIVE`, 240, lines per frame.
- `ADDR_W`, 17, RAM address width. `H_ACTIVE*V_ACTIVE` must be ≤ 2^ADDR_W; this is checked at elaboration.

Ports:
- `clk_out`, input, 1: system clock (PLL output). Same clock as RAM `clka`.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `frame_start`, input, 1: single-cycle pulse marking the first pixel of a frame.
- `pix_valid`, input, 1: `pix_in` is valid this cycle.
- `pix_in`, input, 1: binary pixel.
- `err_clr`, input, 1: clears the sticky error flags.
- `wr_ce`, output, 1: RAM write enable. Drives `cea`.
- `wr_addr`, output, ADDR_W: RAM write address. Drives `ada`.
- `wr_din`, output, 1: RAM write data. Drives `din`.
- `busy`, output, 1: high while in WRITE.
- `frame_done`, output, 1: one-cycle pulse after the last write of a complete frame.
- `frame_cnt`, output, 8: count of completed frames. Wraps 255→0.
- `short_frame`, output, 1: sticky. Set when `frame_start` arrives while in WRITE.
- `overrun`, output, 1: sticky. Set when a pixel arrives outside a frame.

## Operation

- **FSM states:** IDLE, WRITE, DONE.
- **IDLE:**
  - `frame_start` → WRITE. Address counter is set to 0.
  - If `pix_valid` is also high, that pixel is written at address 0 and the counter becomes 1.
  - `pix_valid` without `frame_start` → pixel dropped, `overrun` set.
- **WRITE:**
  - Each `pix_valid` writes `pix_in` at the current address, then the address increments.
  - If the address written equals `H_ACTIVE*V_ACTIVE-1`, the FSM goes to DONE.
  - Gaps in `pix_valid` are allowed; the address holds during gaps.
- **`frame_start` while in WRITE:**
  - `short_frame` is set, the address restarts at 0, and the FSM stays in WRITE.
  - A coincident valid pixel is written at address 0.
  - `frame_cnt` is not incremented.
- **DONE** (exactly 1 cycle):
  - `frame_done`=1 and `frame_cnt` increments.
  - Next state is IDLE, or WRITE if `frame_start` is high in this cycle; its pixel, if valid, is written at address 0.
  - `pix_valid` without `frame_start` in DONE → dropped, `overrun` set.
- **Address arithmetic:** the counter is ADDR_W bits and never exceeds `H_ACTIVE*V_ACTIVE-1`. No row/column split is needed; the RAM is linear raster.
- **Error flags:** `err_clr` clears both flags. If a set event coincides with `err_clr`, set wins.
- **Reset values:**
  - State IDLE.
  - `wr_ce`=0, `wr_addr`=0, `wr_din`=0.
  - `busy`=0, `frame_done`=0, `frame_cnt`=0, `short_frame`=0, `overrun`=0.
- **Reset mid-frame:** all state is abandoned. No `frame_done` is issued, and `wr_ce` is 0 from the cycle after `rst_n` is sampled low.

## Timing

- **Registered write outputs:** `wr_ce`, `wr_addr` and `wr_din` are registered. For an accepted pixel at cycle N, the write appears at N+1 with `wr_ce`=1 for exactly one cycle per pixel.
- **`wr_ce` low cycles:** `wr_addr` and `wr_din` hold their last value.
- **Last-pixel sequence:** last pixel accepted at N, last write at N+1 (`wr_ce`=1). `frame_done` at N+1 (state DONE during N+1). IDLE from N+2, unless `frame_start` arrives at N+1.
- **`busy`:** a registered copy of state==WRITE. It rises the cycle after `frame_start` and falls the cycle after the last accepted pixel.
- **Throughput:** one pixel per cycle sustained, including back-to-back frames (`frame_start` in the DONE cycle).
- **Sticky flags:** they assert one cycle after the causing event.

## Test plan

- **Full frame, continuous valid.** H=4, V=2, `frame_start`+valid at cycle 0, 8 pixels pattern 10110010. Required: writes to addr 0..7 on cycles 1..8 with matching `din`; `frame_done` on cycle 8; `frame_cnt`=1; no error flags.
- **Gapped valid.** Same frame with `pix_valid` toggling every other cycle. Required: addresses 0..7 contiguous; `wr_ce` low during gaps; `frame_done` one cycle after the 8th accepted pixel.
- **Short frame.** `frame_start` after 3 pixels. Required: `short_frame`=1; next write at addr 0; the 8 following pixels complete the frame; `frame_cnt`=1, not 2.
- **Stray pixels.** Valid pixels in IDLE and in the DONE cycle without `frame_start`. Required: no `wr_ce`; `overrun`=1. Then `err_clr` → `overrun`=0.
- **Back-to-back frames.** `frame_start` asserted in the DONE cycle, 3 consecutive frames. Required: 24 writes with no bubble; addr sequence 0..7 ×3; `frame_cnt`=3. Repeat 256 frames → `frame_cnt` wraps to 0.
- **Reset mid-frame.** `rst_n`=0 after 5 pixels. Required: all outputs at reset values the next cycle. After release, the next frame starts at addr 0, and `frame_cnt` and the flags are 0.
